// File: rtl/param_divider.sv
// Sequential restoring divider, one quotient bit per clock, with optional
// signed operation and a divide-by-zero shortcut that bypasses the step loop.
module param_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is taken on any rising edge where the FSM is in IDLE or
  // DONE; done pulses for the cycle in which results first become valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] qacc;
  logic [WIDTH:0]   part;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             zero_div;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   part_shift;
  logic             fits;
  logic [WIDTH:0]   part_new;
  logic [WIDTH-1:0] q_new;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             last_step;

  assign accept       = start && (state != CALC);
  assign zero_div     = (divisor == '0);
  assign dividend_neg = sign_mode && dividend[WIDTH-1];
  assign divisor_neg  = sign_mode && divisor[WIDTH-1];
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg ? -divisor : divisor;

  // Partial remainder is one bit wider than the operands so the shifted value
  // never overflows, even for the largest unsigned divisor.
  assign part_shift = {part[WIDTH-1:0], dvd[WIDTH-1]};
  assign fits       = (part_shift >= {1'b0, dvs});
  assign part_new   = fits ? (part_shift - {1'b0, dvs}) : part_shift;
  assign q_new      = {qacc[WIDTH-2:0], fits};
  assign q_final    = neg_q ? -q_new : q_new;
  assign r_final    = neg_r ? -part_new[WIDTH-1:0] : part_new[WIDTH-1:0];
  assign last_step  = (count == CW'(1));

  assign busy      = (state == CALC);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = zero_div ? DONE : CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: begin
        if (start) state_next = zero_div ? DONE : CALC;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      dvd       <= '0;
      dvs       <= '0;
      qacc      <= '0;
      part      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (zero_div) begin
          quotient  <= '1;
          remainder <= dividend;
          div_zero  <= 1'b1;
          count     <= '0;
        end else begin
          dvd   <= dividend_mag;
          dvs   <= divisor_mag;
          qacc  <= '0;
          part  <= '0;
          neg_q <= dividend_neg ^ divisor_neg;
          neg_r <= dividend_neg;
          count <= CW'(WIDTH);
        end
      end else if (state == CALC) begin
        part  <= part_new;
        dvd   <= dvd << 1;
        qacc  <= q_new;
        count <= count - CW'(1);
        if (last_step) begin
          quotient  <= q_final;
          remainder <= r_final;
          div_zero  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_divider.sv
// Directed bench for param_divider: a 32-bit and an 8-bit instance driven by a
// linear sequence of steps with hand-computed expected results.
module tb_param_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        sign_mode;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [1:0]  dbg_state;

  logic        n_start;
  logic        n_sign_mode;
  logic [7:0]  n_dividend;
  logic [7:0]  n_divisor;
  logic [7:0]  n_quotient;
  logic [7:0]  n_remainder;
  logic        n_busy;
  logic        n_done;
  logic        n_div_zero;
  logic [1:0]  n_dbg_state;

  int total = 0;
  int bad   = 0;

  param_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .sign_mode(sign_mode),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero),
    .dbg_state(dbg_state)
  );

  param_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(n_start), .sign_mode(n_sign_mode),
    .dividend(n_dividend), .divisor(n_divisor), .quotient(n_quotient),
    .remainder(n_remainder), .busy(n_busy), .done(n_done), .div_zero(n_div_zero),
    .dbg_state(n_dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one 32-bit request, then count cycles spent busy (bounded).
  task automatic run32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                       output int busy_cycles);
    sign_mode = sm;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
  endtask

  int bc;
  int done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; sign_mode = 1'b0; dividend = '0; divisor = '0;
    n_start = 1'b0; n_sign_mode = 1'b0; n_dividend = '0; n_divisor = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("reset_q", quotient, 32'h0);
    chk("reset_r", remainder, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_dz", {31'b0, div_zero}, 32'h0);
    chk("reset_state", {30'b0, dbg_state}, 32'h0);

    // unsigned 100/7
    run32(1'b0, 32'd100, 32'd7, bc);
    chk("u100_7_busy_cycles", bc, 32'd32);
    chk("u100_7_done", {31'b0, done}, 32'h1);
    chk("u100_7_q", quotient, 32'd14);
    chk("u100_7_r", remainder, 32'd2);
    chk("u100_7_dz", {31'b0, div_zero}, 32'h0);
    tick();
    chk("u100_7_done_pulse", {31'b0, done}, 32'h0);
    chk("u100_7_idle", {30'b0, dbg_state}, 32'h0);
    chk("u100_7_q_hold", quotient, 32'd14);

    // signed cases
    run32(1'b1, 32'hFFFF_FFF9, 32'd2, bc);
    chk("s_m7_2_q", quotient, 32'hFFFF_FFFD);
    chk("s_m7_2_r", remainder, 32'hFFFF_FFFF);
    tick();
    run32(1'b1, 32'd7, 32'hFFFF_FFFE, bc);
    chk("s_7_m2_q", quotient, 32'hFFFF_FFFD);
    chk("s_7_m2_r", remainder, 32'd1);
    tick();
    run32(1'b1, 32'hFFFF_FFF8, 32'd3, bc);
    chk("s_m8_3_q", quotient, 32'hFFFF_FFFE);
    chk("s_m8_3_r", remainder, 32'hFFFF_FFFE);
    tick();
    // same bit patterns as unsigned: 0xFFFFFFF8 / 3
    run32(1'b0, 32'hFFFF_FFF8, 32'd3, bc);
    chk("u_big_3_q", quotient, 32'h5555_5552);
    chk("u_big_3_r", remainder, 32'd2);
    tick();

    // divide by zero, both modes
    run32(1'b0, 32'd5, 32'd0, bc);
    chk("z5_busy_cycles", bc, 32'd0);
    chk("z5_done", {31'b0, done}, 32'h1);
    chk("z5_q", quotient, 32'hFFFF_FFFF);
    chk("z5_r", remainder, 32'd5);
    chk("z5_dz", {31'b0, div_zero}, 32'h1);
    tick();
    run32(1'b1, 32'hFFFF_FFFB, 32'd0, bc);
    chk("zm5_r_raw", remainder, 32'hFFFF_FFFB);
    chk("zm5_dz", {31'b0, div_zero}, 32'h1);
    tick();
    chk("zm5_dz_hold", {31'b0, div_zero}, 32'h1);
    run32(1'b0, 32'd9, 32'd3, bc);
    chk("u9_3_q", quotient, 32'd3);
    chk("u9_3_r", remainder, 32'd0);
    chk("u9_3_dz_clear", {31'b0, div_zero}, 32'h0);
    tick();

    // signed overflow with a start pulse in CALC that must be ignored
    sign_mode = 1'b1; dividend = 32'h8000_0000; divisor = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (bc == 10) begin
        sign_mode = 1'b0; dividend = 32'd1; divisor = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("ovf_busy_cycles", bc, 32'd32);
    chk("ovf_q", quotient, 32'h8000_0000);
    chk("ovf_r", remainder, 32'h0);
    chk("ovf_dz", {31'b0, div_zero}, 32'h0);
    tick();

    // reset in the middle of a division, with a concurrent start
    sign_mode = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_q", quotient, 32'h0);
    chk("rst_r", remainder, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, 32'h0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) done_seen++;
      tick();
    end
    chk("rst_no_late_done", done_seen, 32'd0);
    run32(1'b0, 32'd100, 32'd7, bc);
    chk("post_rst_cycles", bc, 32'd32);
    chk("post_rst_q", quotient, 32'd14);
    tick();

    // 8-bit instance, back-to-back start from DONE
    n_sign_mode = 1'b0; n_dividend = 8'd200; n_divisor = 8'd3; n_start = 1'b1;
    tick();
    n_start = 1'b0;
    bc = 0;
    while (n_busy && bc < 50) begin
      bc++;
      tick();
    end
    chk("n200_3_cycles", bc, 32'd8);
    chk("n200_3_done", {31'b0, n_done}, 32'h1);
    chk("n200_3_q", {24'b0, n_quotient}, 32'd66);
    chk("n200_3_r", {24'b0, n_remainder}, 32'd2);
    n_dividend = 8'd255; n_divisor = 8'd16; n_start = 1'b1;
    tick();
    n_start = 1'b0;
    chk("n_b2b_busy", {31'b0, n_busy}, 32'h1);
    bc = 0;
    while (n_busy && bc < 50) begin
      bc++;
      tick();
    end
    chk("n255_16_cycles", bc, 32'd8);
    chk("n255_16_q", {24'b0, n_quotient}, 32'd15);
    chk("n255_16_r", {24'b0, n_remainder}, 32'd15);
    tick();
    chk("n_idle", {30'b0, n_dbg_state}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
